booth_mult_sched: RTL and testbench

- Sequential radix-2 Booth multiplier shared between NREQ requesters.
- A round-robin arbiter grants one request at a time. An iterative datapath then performs one Booth step per cycle.
- The result is returned on a single valid/ready response channel tagged with the requester ID.
- Replaces per-client combinational Booth arrays where area matters more than latency.

---
 rtl/booth_mult_sched_if.sv | 29 ++
 rtl/booth_mult_sched.sv | 161 ++++++++++++++++
 tb/tb_booth_mult_sched.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_sched_if.sv
// Request/response bundle for the shared Booth multiplier.
interface booth_mult_sched_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 2
);
  localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2*WIDTH-1:0]    rsp_product;
  logic [ID_W-1:0]       rsp_id;
  logic                  busy;

  // Requester / result-consumer side
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_product, rsp_id, busy
  );

  // Multiplier side
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_product, rsp_id, busy
  );
endinterface

// File: rtl/booth_mult_sched.sv
// Radix-2 Booth multiplier time-shared between NREQ requesters through a
// round-robin arbiter; one Booth step per cycle, result on a tagged
// valid/ready channel.
module booth_mult_sched #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  booth_mult_sched_if.slave bus
);
  localparam int unsigned ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned P_W    = 2 * WIDTH;
  localparam int unsigned STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [P_W-1:0]      a_sh, a_d;
  logic [WIDTH-1:0]    b_sh, b_d;
  logic                b_prev, bp_d;
  logic [P_W-1:0]      acc, acc_d, acc_n;
  logic [STEP_W-1:0]   step, step_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ID_W-1:0]     last_grant, lg_d;
  logic                rsp_valid_q, rv_d;
  logic [P_W-1:0]      rsp_product_q, rp_d;
  logic [ID_W-1:0]     rsp_id_q, ri_d;
  logic                busy_q, busy_d;

  logic [ID_W-1:0]     grant;
  logic                grant_hit;
  int unsigned         idx;

  logic [WIDTH-1:0]    a_arr [NREQ];
  logic [WIDTH-1:0]    b_arr [NREQ];

  // Unpack the flat operand buses per requester
  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign a_arr[k] = bus.req_a[k*WIDTH +: WIDTH];
    assign b_arr[k] = bus.req_b[k*WIDTH +: WIDTH];
  end

  // Round-robin pick: first valid requester after the last one served
  always_comb begin
    grant     = '0;
    grant_hit = 1'b0;
    idx       = 0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = (32'(last_grant) + off) % NREQ;
      if (!grant_hit && bus.req_valid[ID_W'(idx)]) begin
        grant_hit = 1'b1;
        grant     = ID_W'(idx);
      end
    end
  end

  // Next-state, datapath and handshake decode
  always_comb begin
    state_d       = state;
    a_d           = a_sh;
    b_d           = b_sh;
    bp_d          = b_prev;
    acc_d         = acc;
    acc_n         = acc;
    step_d        = step;
    id_d          = id_q;
    lg_d          = last_grant;
    rv_d          = rsp_valid_q;
    rp_d          = rsp_product_q;
    ri_d          = rsp_id_q;
    bus.req_ready = '0;

    unique case (state)
      IDLE: begin
        if (grant_hit) begin
          bus.req_ready[grant] = 1'b1;
          if (bus.req_valid[grant]) begin
            a_d     = {{WIDTH{a_arr[grant][WIDTH-1]}}, a_arr[grant]};
            b_d     = b_arr[grant];
            bp_d    = 1'b0;
            acc_d   = '0;
            step_d  = '0;
            id_d    = grant;
            lg_d    = grant;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // a_sh already carries the shift by i; b_sh[0] is b[i], b_prev is b[i-1]
        unique case ({b_sh[0], b_prev})
          2'b01:   acc_n = acc + a_sh;
          2'b10:   acc_n = acc - a_sh;
          default: acc_n = acc;
        endcase
        acc_d  = acc_n;
        a_d    = a_sh << 1;
        b_d    = b_sh >> 1;
        bp_d   = b_sh[0];
        step_d = step + STEP_W'(1);
        if (step == STEP_W'(WIDTH - 1)) begin
          rp_d    = acc_n;
          ri_d    = id_q;
          rv_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_sh          <= '0;
      b_sh          <= '0;
      b_prev        <= 1'b0;
      acc           <= '0;
      step          <= '0;
      id_q          <= '0;
      last_grant    <= ID_W'(NREQ - 1);
      rsp_valid_q   <= 1'b0;
      rsp_product_q <= '0;
      rsp_id_q      <= '0;
      busy_q        <= 1'b0;
    end else begin
      state         <= state_d;
      a_sh          <= a_d;
      b_sh          <= b_d;
      b_prev        <= bp_d;
      acc           <= acc_d;
      step          <= step_d;
      id_q          <= id_d;
      last_grant    <= lg_d;
      rsp_valid_q   <= rv_d;
      rsp_product_q <= rp_d;
      rsp_id_q      <= ri_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_product = rsp_product_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_booth_mult_sched.sv
// Self-checking bench for booth_mult_sched: directed table, hand sequences
// for backpressure/contention/reset, exhaustive sweep and a randomized run
// against a cycle-level reference model.
module tb_booth_mult_sched;
  localparam int W  = 4;
  localparam int N  = 2;
  localparam int PW = 2 * W;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 0;

  booth_mult_sched_if #(.WIDTH(W), .NREQ(N)) bus ();

  booth_mult_sched #(.WIDTH(W), .NREQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            k;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] p;
  } vec_t;

  typedef struct {
    int            id;
    logic [PW-1:0] p;
  } rsp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Exact signed product reduced to 2*W bits
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return PW'(p);
  endfunction

  // Round-robin rule: first valid requester after 'last', with wrap
  function automatic int pick(input int last, input logic [N-1:0] v);
    for (int off = 1; off <= N; off++) begin
      int i;
      i = (last + off) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Protocol invariants sampled every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
      if (bus.busy) chk("ready_while_busy", 32'(bus.req_ready), 32'd0);
    end
  end

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_product", 32'(bus.rsp_product), 32'd0);
    chk("rst_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    mon_en = 1'b1;
  endtask

  // Present a request and wait (bounded) until it is accepted; returns at
  // the falling edge following the accept edge.
  task automatic accept(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    bus.req_valid[k]       = 1'b1;
    bus.req_a[k*W +: W]    = a;
    bus.req_b[k*W +: W]    = b;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (bus.req_ready[k]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_seen", 32'(ok), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid[k] = 1'b0;
  endtask

  task automatic wait_rsp(input logic [PW-1:0] p, input int id, input string tag);
    int lat;
    lat = 0;
    while (!bus.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(W));
    chk({tag, "_product"}, 32'(bus.rsp_product), 32'(p));
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic do_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [PW-1:0] p, input string tag);
    accept(k, a, b);
    wait_rsp(p, k, tag);
    @(negedge clk);
    chk({tag, "_idle_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_held_product"}, 32'(bus.rsp_product), 32'(p));
  endtask

  vec_t tbl [6];
  rsp_t exp_q [$];

  initial begin
    rsp_t r;
    int   m_last, m_run, nacc, nrsp, g;
    bit   m_done;
    logic [N-1:0] exp_rdy;

    tbl[0] = '{k: 0, a: 4'd3,   b: 4'd5,   p: 8'h0F};
    tbl[1] = '{k: 1, a: 4'h8,   b: 4'h8,   p: 8'h40};
    tbl[2] = '{k: 1, a: 4'd7,   b: 4'h8,   p: 8'hC8};
    tbl[3] = '{k: 1, a: 4'hF,   b: 4'd1,   p: 8'hFF};
    tbl[4] = '{k: 1, a: 4'd0,   b: 4'hB,   p: 8'h00};
    tbl[5] = '{k: 0, a: 4'hA,   b: 4'h9,   p: 8'h2A};

    do_reset();

    // Directed vectors
    for (int i = 0; i < 6; i++)
      do_op(tbl[i].k, tbl[i].a, tbl[i].b, tbl[i].p, $sformatf("vec%0d", i));

    // Backpressure: result held while a request waits
    bus.rsp_ready = 1'b0;
    accept(0, 4'd2, 4'd3);
    wait_rsp(8'h06, 0, "bp");
    bus.req_valid[0] = 1'b1;
    bus.req_a[0 +: W] = 4'd1;
    bus.req_b[0 +: W] = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_product", 32'(bus.rsp_product), 32'h06);
      chk("bp_hold_id", 32'(bus.rsp_id), 32'd0);
      chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp_release_busy", 32'(bus.busy), 32'd0);
    chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
    accept(0, 4'd1, 4'd1);
    wait_rsp(8'h01, 0, "bp2");
    @(negedge clk);

    // Contention: both requesters held valid, grants must alternate from 0
    do_reset();
    bus.req_a = {4'hE, 4'd3};
    bus.req_b = {4'd5, 4'd2};
    bus.req_valid = 2'b11;
    m_last = N - 1;
    nacc = 0;
    nrsp = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 100 && nrsp < 4; cyc++) begin
      if (nacc == 4) bus.req_valid = '0;
      #1;
      if (bus.req_ready != '0) begin
        g = pick(m_last, 2'b11);
        chk("cont_grant", 32'(bus.req_ready), 32'(1 << g));
        r.id = g;
        r.p  = (g == 0) ? ref_mul(4'd3, 4'd2) : ref_mul(4'hE, 4'd5);
        exp_q.push_back(r);
        m_last = g;
        nacc++;
      end
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("cont_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          r = exp_q.pop_front();
          chk("cont_rsp_id", 32'(bus.rsp_id), 32'(r.id));
          chk("cont_rsp_product", 32'(bus.rsp_product), 32'(r.p));
        end
        nrsp++;
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    chk("cont_rsp_count", 32'(nrsp), 32'd4);
    repeat (3) @(negedge clk);

    // Exhaustive sweep with a random requester per operation
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_op(int'($urandom_range(0, N - 1)), W'(a), W'(b), ref_mul(W'(a), W'(b)), "sweep");

    // Random traffic against a cycle-level reference model
    do_reset();
    m_last = N - 1;
    m_run  = 0;
    m_done = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      bus.req_valid = N'($urandom_range(0, (1 << N) - 1));
      bus.req_a     = (N*W)'($urandom);
      bus.req_b     = (N*W)'($urandom);
      bus.rsp_ready = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = '0;
      g = -1;
      if (m_run == 0 && !m_done) begin
        g = pick(m_last, bus.req_valid);
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      chk("rnd_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(m_done));
      if (m_done && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_queue_empty", 32'd1, 32'd0);
        end else begin
          r = exp_q.pop_front();
          chk("rnd_rsp_id", 32'(bus.rsp_id), 32'(r.id));
          chk("rnd_rsp_product", 32'(bus.rsp_product), 32'(r.p));
        end
      end
      if (g >= 0) begin
        r.id = g;
        r.p  = ref_mul(bus.req_a[g*W +: W], bus.req_b[g*W +: W]);
        exp_q.push_back(r);
        m_last = g;
        m_run  = W;
      end else if (m_run > 0) begin
        m_run--;
        if (m_run == 0) m_done = 1'b1;
      end else if (m_done && bus.rsp_ready) begin
        m_done = 1'b0;
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (W + 4) @(negedge clk);

    // Reset during RUN step 2 aborts the operation and restores priority
    accept(0, 4'd5, 4'd5);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_product", 32'(bus.rsp_product), 32'd0);
    chk("abort_id", 32'(bus.rsp_id), 32'd0);
    nrsp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) nrsp++;
    end
    chk("abort_no_rsp", 32'(nrsp), 32'd0);
    bus.req_valid[1]  = 1'b1;
    bus.req_a[W +: W] = 4'd2;
    bus.req_b[W +: W] = 4'd2;
    bus.req_valid[0]  = 1'b1;
    bus.req_a[0 +: W] = 4'hD;
    bus.req_b[0 +: W] = 4'd4;
    #1;
    chk("abort_prio", 32'(bus.req_ready), 32'd1);
    accept(0, 4'hD, 4'd4);
    bus.req_valid = '0;
    wait_rsp(8'hF4, 0, "post_abort");
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
